// File: rtl/conv_test_vector_gen.sv
// Stimulus source for the conv datapath. It presents vectors from a writable memory or from
// a Galois LFSR over a valid/ready handshake. It also drives a register bank of kernel lanes.
module conv_test_vector_gen #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned LANES  = 4,
  parameter int unsigned LEN_W  = 8,
  parameter logic [63:0] SEED   = 64'h1,
  parameter logic [63:0] POLY   = 64'hD800000000000000,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic [LEN_W-1:0]        burst_len,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    kwr_en,
  input  logic [LW-1:0]           kwr_lane,
  input  logic [DATA_W-1:0]       kwr_data,
  output logic                    valid,
  input  logic                    ready,
  output logic [DATA_W-1:0]       in_data,
  output logic [LANES*DATA_W-1:0] kernel,
  output logic                    busy,
  output logic                    done,
  output logic [AW-1:0]           index,
  output logic [15:0]             beats
);

  localparam logic [DATA_W-1:0] SeedW   = DATA_W'(SEED);
  localparam logic [DATA_W-1:0] PolyW   = DATA_W'(POLY);
  localparam logic [AW-1:0]     LastIdx = AW'(DEPTH - 1);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e            state_q, state_d;
  logic              src_q, src_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              done_q, done_d;
  logic [AW-1:0]     index_q, index_d;
  logic [DATA_W-1:0] lfsr_q, lfsr_d;
  logic [15:0]       beats_q, beats_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] kernel_q [LANES];

  logic idle;

  assign idle = (state_q == StIdle);

  // Next-state: sequence control and source advance on each accepted beat
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    index_d = index_q;
    lfsr_d  = lfsr_q;
    beats_d = beats_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          src_d = mode[0];
          rem_d = mode[1] ? burst_len : LEN_W'(1);
          // A zero-length burst completes immediately without issuing a beat
          if (rem_d != '0) state_d = StSend;
          else             done_d  = 1'b1;
        end
      end
      StSend: begin
        if (ready) begin
          beats_d = beats_q + 16'd1;
          rem_d   = rem_q - LEN_W'(1);
          if (src_q) begin
            lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ PolyW) : (lfsr_q >> 1);
          end else begin
            index_d = (index_q == LastIdx) ? '0 : index_q + AW'(1);
          end
          if (rem_q == LEN_W'(1)) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control and source state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      src_q   <= 1'b0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      index_q <= '0;
      lfsr_q  <= SeedW;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      index_q <= index_d;
      lfsr_q  <= lfsr_d;
      beats_q <= beats_d;
    end
  end

  // Vector memory: no reset, writable only while idle
  always_ff @(posedge clk) begin
    if (idle && wr_en && (32'(wr_addr) < DEPTH)) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Kernel lanes: writable only while idle, out-of-range lanes dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kernel_q <= '{default: '0};
    end else if (idle && kwr_en && (32'(kwr_lane) < LANES)) begin
      kernel_q[kwr_lane] <= kwr_data;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_kernel
    assign kernel[i*DATA_W +: DATA_W] = kernel_q[i];
  end

  assign valid   = (state_q == StSend);
  assign busy    = valid;
  assign done    = done_q;
  assign index   = index_q;
  assign beats   = beats_q;
  // Source state only moves on accept, so the presented vector is stable under backpressure
  assign in_data = src_q ? lfsr_q : mem_q[index_q];

endmodule
